// File: rtl/int_controller_if.sv
// int_controller_if: request/acknowledge and configuration bundle between the CPU-side logic
// and the interrupt controller.
//   irq        peripheral request lines (a request is a rising edge)
//   ien        global interrupt enable
//   mask_we    mask register write strobe; mask_wdata is the new mask (1 = source enabled)
//   inta/iret  acknowledge and return-from-interrupt pulses from the control unit
//   intp       interrupt request to the control unit
//   vector     service-routine address of the selected source
//   irq_id     index of the selected / in-service source
//   pending    latched, not-yet-acknowledged requests
//   in_service high while a routine is being serviced
// master drives requests and control pulses; slave is the controller.
interface int_controller_if #(
   parameter int unsigned N_SRC = 4,
   parameter int unsigned VEC_W = 8
);
   logic [N_SRC-1:0] irq;
   logic             ien;
   logic             mask_we;
   logic [N_SRC-1:0] mask_wdata;
   logic             inta;
   logic             iret;
   logic             intp;
   logic [VEC_W-1:0] vector;
   logic [2:0]       irq_id;
   logic [N_SRC-1:0] pending;
   logic             in_service;

   modport master (
      output irq, ien, mask_we, mask_wdata, inta, iret,
      input  intp, vector, irq_id, pending, in_service
   );

   modport slave (
      input  irq, ien, mask_we, mask_wdata, inta, iret,
      output intp, vector, irq_id, pending, in_service
   );
endinterface

// File: rtl/int_controller.sv
// int_controller: edge-triggered interrupt controller with per-source mask, global enable and
// fixed lowest-index-wins priority. Raises intp, holds it until inta, then tracks the
// in-service source until iret. No nesting.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  int_controller_if.slave (irq, ien, mask_we, mask_wdata, inta, iret in;
//        intp, vector, irq_id, pending, in_service out)
// All outputs come straight from flops.
module int_controller #(
   parameter int unsigned           N_SRC      = 4,
   parameter int unsigned           VEC_W      = 8,
   parameter logic [VEC_W-1:0]      VEC_BASE   = 8'hF0,
   parameter int unsigned           VEC_STRIDE = 4
) (
   input logic                 clk,
   input logic                 rst,
   int_controller_if.slave     bus
);

   typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

   state_e           state_q,      state_d;
   logic [N_SRC-1:0] irq_q,        irq_d;
   logic [N_SRC-1:0] pending_q,    pending_d;
   logic [N_SRC-1:0] mask_q,       mask_d;
   logic [2:0]       irq_id_q,     irq_id_d;
   logic [VEC_W-1:0] vector_q,     vector_d;
   logic             intp_q,       intp_d;
   logic             in_service_q, in_service_d;

   logic [N_SRC-1:0] irq_edge;
   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] clr;
   logic             win_found;
   logic [2:0]       win_id;
   logic [VEC_W-1:0] win_vec;

   always_comb begin
      irq_edge = bus.irq & ~irq_q;
      eligible = pending_q & mask_q & {N_SRC{bus.ien}};

      // Scan high to low so the lowest eligible index is the last one written.
      win_found = 1'b0;
      win_id    = 3'd0;
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_found = 1'b1;
            win_id    = 3'(i);
         end
      end
      // VEC_W-wide arithmetic, so the address wraps mod 2^VEC_W.
      win_vec = VEC_BASE + VEC_W'(win_id) * VEC_W'(VEC_STRIDE);
   end

   always_comb begin
      state_d      = state_q;
      irq_d        = bus.irq;
      mask_d       = bus.mask_we ? bus.mask_wdata : mask_q;
      irq_id_d     = irq_id_q;
      vector_d     = vector_q;
      intp_d       = intp_q;
      in_service_d = in_service_q;
      clr          = '0;

      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               state_d  = StReq;
               intp_d   = 1'b1;
               irq_id_d = win_id;
               vector_d = win_vec;
            end
         end
         // Mask/ien changes here do not withdraw the request.
         StReq: begin
            if (bus.inta) begin
               state_d      = StService;
               intp_d       = 1'b0;
               in_service_d = 1'b1;
               for (int i = 0; i < int'(N_SRC); i++) begin
                  if (irq_id_q == 3'(i)) clr[i] = 1'b1;
               end
            end
         end
         StService: begin
            if (bus.iret) begin
               state_d      = StIdle;
               in_service_d = 1'b0;
            end
         end
         default: begin
            state_d      = StIdle;
            intp_d       = 1'b0;
            in_service_d = 1'b0;
         end
      endcase

      // A fresh edge in the same cycle as the acknowledge clear keeps the bit set.
      pending_d = (pending_q & ~clr) | irq_edge;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         irq_q        <= '0;
         pending_q    <= '0;
         mask_q       <= '0;
         irq_id_q     <= 3'd0;
         vector_q     <= VEC_BASE;
         intp_q       <= 1'b0;
         in_service_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         irq_q        <= irq_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         irq_id_q     <= irq_id_d;
         vector_q     <= vector_d;
         intp_q       <= intp_d;
         in_service_q <= in_service_d;
      end
   end

   assign bus.intp       = intp_q;
   assign bus.vector     = vector_q;
   assign bus.irq_id     = irq_id_q;
   assign bus.pending    = pending_q;
   assign bus.in_service = in_service_q;

endmodule
